// File: rtl/systolic_output_writer.sv
// Write-back stage for the systolic array: gathers column-staggered results into a
// row buffer, then streams one packed row per cycle to RAM and handshakes with the FSM.
module systolic_output_writer #(
  parameter int          ROWS          = 4,
  parameter int          COLS          = 4,
  parameter int          WORD_SIZE     = 16,
  parameter logic [31:0] OUT_BASE_ADDR = 32'h0000_0200,
  parameter int          ADDR_INCR     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_fsm,
  input  logic                      stall,
  input  logic                      fsm_done,
  input  logic [COLS*WORD_SIZE-1:0] matmul_output,
  input  logic [COLS-1:0]           output_col_valid,
  output logic                      wr_output_rdy,
  output logic                      wr_output_done,
  output logic                      wr_active,
  output logic [31:0]               wr_mem_addr,
  output logic                      wr_mem_en,
  output logic [COLS*WORD_SIZE-1:0] wr_mem_data,
  output logic                      err_overflow,
  output logic                      err_underflow
);

  localparam int CW = $clog2(ROWS) + 1;
  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {IDLE, CAPTURE, DRAIN, DONE, RELEASE} state_t;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] row_buf [ROWS][COLS];
  logic [CW-1:0]        row_cnt [COLS];
  logic [IW-1:0]        drain_idx;
  logic [COLS-1:0]      cap_en;
  logic [COLS-1:0]      col_full_nxt;
  logic                 overflow_hit;

  // Per-column capture decision; fullness includes this cycle's captures.
  always_comb begin
    cap_en       = '0;
    col_full_nxt = '0;
    overflow_hit = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (state == CAPTURE && !stall && output_col_valid[c]) begin
        if (row_cnt[c] < CW'(ROWS)) cap_en[c] = 1'b1;
        else                        overflow_hit = 1'b1;
      end
      col_full_nxt[c] = ((row_cnt[c] + CW'(cap_en[c])) == CW'(ROWS));
    end
  end

  always_comb begin
    state_nxt      = state;
    wr_output_rdy  = 1'b0;
    wr_output_done = 1'b0;
    wr_active      = 1'b0;
    wr_mem_en      = 1'b0;
    wr_mem_addr    = '0;
    wr_mem_data    = '0;
    case (state)
      IDLE: begin
        wr_output_rdy = 1'b1;
        if (start_fsm) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (fsm_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        wr_active   = 1'b1;
        wr_mem_en   = 1'b1;
        wr_mem_addr = OUT_BASE_ADDR + 32'(drain_idx) * 32'(ADDR_INCR);
        for (int c = 0; c < COLS; c++)
          wr_mem_data[c*WORD_SIZE +: WORD_SIZE] = row_buf[drain_idx][c];
        if (drain_idx == IW'(ROWS - 1)) state_nxt = DONE;
      end
      DONE: begin
        wr_output_done = 1'b1;
        state_nxt      = RELEASE;
      end
      RELEASE: begin
        if (!fsm_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer contents and error flags are cleared at each new start so missing
  // entries drain as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      drain_idx     <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          row_buf[r][c] <= '0;
      for (int c = 0; c < COLS; c++)
        row_cnt[c] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          drain_idx <= '0;
          if (start_fsm) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            for (int r = 0; r < ROWS; r++)
              for (int c = 0; c < COLS; c++)
                row_buf[r][c] <= '0;
            for (int c = 0; c < COLS; c++)
              row_cnt[c] <= '0;
          end
        end
        CAPTURE: begin
          drain_idx <= '0;
          for (int c = 0; c < COLS; c++) begin
            if (cap_en[c]) begin
              row_buf[row_cnt[c][IW-1:0]][c] <= matmul_output[c*WORD_SIZE +: WORD_SIZE];
              row_cnt[c]                     <= row_cnt[c] + CW'(1);
            end
          end
          if (overflow_hit) err_overflow <= 1'b1;
          if (fsm_done && !(&col_full_nxt)) err_underflow <= 1'b1;
        end
        DRAIN: begin
          drain_idx <= drain_idx + IW'(1);
        end
        default: begin
          drain_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_output_writer.sv
// Scenario bench for the 2x2 output writer: expected RAM writes are queued as
// stimulus is driven and popped by a monitor as the DUT writes.
module tb_systolic_output_writer;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int WORD = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_fsm;
  logic             stall;
  logic             fsm_done;
  logic [COLS*WORD-1:0] matmul_output;
  logic [COLS-1:0]  output_col_valid;
  logic             wr_output_rdy;
  logic             wr_output_done;
  logic             wr_active;
  logic [31:0]      wr_mem_addr;
  logic             wr_mem_en;
  logic [COLS*WORD-1:0] wr_mem_data;
  logic             err_overflow;
  logic             err_underflow;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  systolic_output_writer #(
    .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WORD),
    .OUT_BASE_ADDR(32'h0000_0200), .ADDR_INCR(4)
  ) dut (
    .clk(clk), .rst(rst), .start_fsm(start_fsm), .stall(stall), .fsm_done(fsm_done),
    .matmul_output(matmul_output), .output_col_valid(output_col_valid),
    .wr_output_rdy(wr_output_rdy), .wr_output_done(wr_output_done), .wr_active(wr_active),
    .wr_mem_addr(wr_mem_addr), .wr_mem_en(wr_mem_en), .wr_mem_data(wr_mem_data),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Scoreboard: every RAM write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wr_mem_en === 1'b1) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write got addr=%h data=%h, required no write", wr_mem_addr, wr_mem_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_mem_addr !== e.addr || wr_mem_data !== e.data) begin
          errors++;
          $display("[TB] FAIL write got addr=%h data=%h, required addr=%h data=%h",
                   wr_mem_addr, wr_mem_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] v, input logic [15:0] w0, input logic [15:0] w1);
    output_col_valid = v;
    matmul_output    = {w1, w0};
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [15:0] w0, input logic [15:0] w1);
    exp_q.push_back('{addr: addr, data: {w1, w0}});
  endtask

  task automatic pulse_start();
    start_fsm = 1'b1;
    tick();
    start_fsm = 1'b0;
  endtask

  // Walks DRAIN, DONE and RELEASE after fsm_done has been raised and sampled once.
  task automatic run_to_idle();
    tick();
    tick();
    tick();
    fsm_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start_fsm = 1'b0; stall = 1'b0; fsm_done = 1'b0;
    drive(2'b00, 16'h0, 16'h0);
    repeat (3) tick();
    checks++;
    if ({wr_output_rdy, wr_output_done, wr_active, wr_mem_en} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got rdy/done/act/en=%b, required 1000",
               {wr_output_rdy, wr_output_done, wr_active, wr_mem_en});
    end
    checks++;
    if (wr_mem_addr !== 32'h0 || wr_mem_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_bus got addr=%h data=%h, required 0/0", wr_mem_addr, wr_mem_data);
    end
    checks++;
    if ({err_overflow, err_underflow} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_err got %b, required 00", {err_overflow, err_underflow});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    pulse_start();
    checks++;
    if (wr_output_rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nom_busy got rdy=%b, required 0", wr_output_rdy);
    end
    drive(2'b01, 16'h0011, 16'h0000); tick();
    drive(2'b11, 16'h0021, 16'h0012); tick();
    drive(2'b10, 16'h0000, 16'h0022); tick();
    drive(2'b00, 16'h0000, 16'h0000);
    expect_write(32'h200, 16'h0011, 16'h0012);
    expect_write(32'h204, 16'h0021, 16'h0022);
    fsm_done = 1'b1;
    tick();
    for (int k = 0; k < ROWS; k++) begin
      checks++;
      if (wr_mem_en !== 1'b1 || wr_active !== 1'b1 || wr_output_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL nom_drain%0d got en=%b act=%b done=%b, required 1 1 0",
                 k, wr_mem_en, wr_active, wr_output_done);
      end
      tick();
    end
    checks++;
    if (wr_output_done !== 1'b1 || wr_mem_en !== 1'b0 || wr_active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nom_done got done=%b en=%b act=%b, required 1 0 0",
               wr_output_done, wr_mem_en, wr_active);
    end
    tick();
    checks++;
    if (wr_output_done !== 1'b0 || wr_output_rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nom_release got done=%b rdy=%b, required 0 0", wr_output_done, wr_output_rdy);
    end
    fsm_done = 1'b0;
    tick();
    checks++;
    if (wr_output_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nom_rdy got %b, required 1", wr_output_rdy);
    end
    checks++;
    if (exp_q.size() != 0 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nom_end got pending=%0d ovf=%b unf=%b, required 0 0 0",
               exp_q.size(), err_overflow, err_underflow);
    end
  endtask

  task automatic test_stall();
    pulse_start();
    drive(2'b01, 16'h00AB, 16'h0000);
    stall = 1'b1; tick();
    tick();
    stall = 1'b0; tick();
    drive(2'b01, 16'h00CD, 16'h0000); tick();
    drive(2'b10, 16'h0000, 16'h0B01); tick();
    drive(2'b10, 16'h0000, 16'h0B02); tick();
    drive(2'b00, 16'h0000, 16'h0000);
    expect_write(32'h200, 16'h00AB, 16'h0B01);
    expect_write(32'h204, 16'h00CD, 16'h0B02);
    fsm_done = 1'b1;
    tick();
    run_to_idle();
    checks++;
    if (exp_q.size() != 0 || err_overflow !== 1'b0 || err_underflow !== 1'b0 || wr_output_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_end got pending=%0d ovf=%b unf=%b rdy=%b, required 0 0 0 1",
               exp_q.size(), err_overflow, err_underflow, wr_output_rdy);
    end
  endtask

  task automatic test_overflow();
    pulse_start();
    drive(2'b11, 16'h0001, 16'h0010); tick();
    drive(2'b11, 16'h0002, 16'h0020); tick();
    drive(2'b01, 16'h0003, 16'h0000); tick();
    drive(2'b00, 16'h0000, 16'h0000);
    checks++;
    if (err_overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_flag got %b, required 1", err_overflow);
    end
    expect_write(32'h200, 16'h0001, 16'h0010);
    expect_write(32'h204, 16'h0002, 16'h0020);
    fsm_done = 1'b1;
    tick();
    run_to_idle();
    checks++;
    if (exp_q.size() != 0 || err_overflow !== 1'b1 || err_underflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_end got pending=%0d ovf=%b unf=%b, required 0 1 0",
               exp_q.size(), err_overflow, err_underflow);
    end
  endtask

  task automatic test_underflow();
    pulse_start();
    checks++;
    if (err_overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unf_clear got ovf=%b, required 0", err_overflow);
    end
    drive(2'b01, 16'hAAAA, 16'h0000); tick();
    drive(2'b00, 16'h0000, 16'h0000);
    expect_write(32'h200, 16'hAAAA, 16'h0000);
    expect_write(32'h204, 16'h0000, 16'h0000);
    fsm_done = 1'b1;
    tick();
    checks++;
    if (err_underflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL unf_flag got %b, required 1", err_underflow);
    end
    run_to_idle();
    checks++;
    if (exp_q.size() != 0 || wr_output_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL unf_end got pending=%0d rdy=%b, required 0 1", exp_q.size(), wr_output_rdy);
    end
  endtask

  task automatic test_reset_mid_drain();
    pulse_start();
    drive(2'b11, 16'h0101, 16'h0102); tick();
    drive(2'b11, 16'h0201, 16'h0202); tick();
    drive(2'b00, 16'h0000, 16'h0000);
    expect_write(32'h200, 16'h0101, 16'h0102);
    fsm_done = 1'b1;
    tick();
    rst      = 1'b1;
    fsm_done = 1'b0;
    tick();
    rst = 1'b0;
    checks++;
    if (wr_mem_en !== 1'b0 || wr_output_rdy !== 1'b1 || wr_active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort got en=%b rdy=%b act=%b, required 0 1 0", wr_mem_en, wr_output_rdy, wr_active);
    end
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0 || wr_output_done !== 1'b0 || wr_output_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_end got pending=%0d done=%b rdy=%b, required 0 0 1",
               exp_q.size(), wr_output_done, wr_output_rdy);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_overflow();
    test_underflow();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_output_writer.md
Name: systolic_output_writer

Overview:
Write-back end of the systolic matmul flow. Captures the skewed, column-staggered results that the matmul FSM presents on its output bus with per-column valid bits. Reassembles them into row-major result rows and writes one row per cycle to RAM. Drives the wr_output_rdy / wr_output_done handshake that gates the FSM's start and releases its FINISH state.

Parameters:
ROWS, 4, systolic rows; number of result rows per column.
COLS, 4, systolic columns; words per result row.
WORD_SIZE, 16, bits per result element.
OUT_BASE_ADDR, 32'h0000_0200, RAM byte address of result row 0.
ADDR_INCR, 4, address step between consecutive result rows.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous active-high reset.
start_fsm  in  1  same start strobe the matmul FSM sees.
stall  in  1  FSM memory stall; no capture while high.
fsm_done  in  1  FSM is in FINISH.
matmul_output  in  COLS*WORD_SIZE  systolic bottom_out; column c at [c*WORD_SIZE +: WORD_SIZE].
output_col_valid  in  COLS  bit c high: column c of matmul_output is valid.
wr_output_rdy  out  1  writer idle; FSM may start.
wr_output_done  out  1  one-cycle pulse: all rows written.
wr_active  out  1  writer owns the RAM write port (top-level address mux select).
wr_mem_addr  out  32  RAM write address.
wr_mem_en  out  1  RAM write enable.
wr_mem_data  out  COLS*WORD_SIZE  RAM write data: one packed result row.
err_overflow  out  1  sticky: a column got more than ROWS samples.
err_underflow  out  1  sticky: fsm_done arrived before every column held ROWS samples.

Behaviour:
- Reset values: wr_output_rdy=1; wr_output_done=0; wr_active=0; wr_mem_en=0; wr_mem_addr=0; wr_mem_data=0; err_*=0. Buffer and counters are cleared, state=IDLE. Reset mid-operation aborts with no further writes.
- Storage: buffer buf[ROWS][COLS] of WORD_SIZE. Per-column counters row_cnt[c] of width clog2(ROWS)+1.
- States: IDLE, CAPTURE, DRAIN, DONE, RELEASE.
- IDLE: wr_output_rdy=1. On start_fsm=1, clear buf to 0, row_cnt to 0 and both err flags; go to CAPTURE with wr_output_rdy=0 the next cycle.
- CAPTURE, per-column capture: on each posedge where output_col_valid[c]=1 and stall=0:
  - if row_cnt[c]<ROWS: buf[row_cnt[c]][c] <= matmul_output word c and row_cnt[c]++;
  - otherwise drop the sample and set err_overflow.
  - All columns are independent and may capture in the same cycle.
- Valid bits held high across stalled cycles are sampled only on non-stall cycles, so no double capture.
- CAPTURE exit:
  - when all row_cnt[c]==ROWS (including the same cycle's captures) and fsm_done=1, go to DRAIN;
  - if fsm_done=1 while any row_cnt[c]<ROWS, set err_underflow and go to DRAIN anyway; missing entries are written as 0.
  - Completion with fsm_done=0 waits in CAPTURE.
- DRAIN: wr_active=1. Cycle k (k=0..ROWS-1): wr_mem_en=1, wr_mem_addr=OUT_BASE_ADDR+k*ADDR_INCR, wr_mem_data=buf[k] packed (column c at [c*WORD_SIZE +: WORD_SIZE]). Exactly ROWS consecutive write cycles, no gaps. After row ROWS-1, go to DONE.
- DONE: wr_mem_en=0, wr_active=0, wr_output_done=1 for exactly one cycle; go to RELEASE.
- RELEASE: wait until fsm_done=0 (the FSM returns to INIT one cycle after seeing done), then IDLE. wr_output_done stays 0.
- Latency: first write is 1 cycle after the CAPTURE exit condition; wr_output_done is ROWS+1 cycles after that exit.
- start_fsm in any state other than IDLE is ignored.
- All address arithmetic is 32-bit unsigned and wraps modulo 2^32.

Test Plan:
1. Reset, ROWS=COLS=2, WORD=16 -> wr_output_rdy=1, wr_mem_en=0, wr_output_done=0, err flags 0.
2. Nominal 2x2: start; col0 valid with 0x0011 then 0x0021; col1 one cycle later with 0x0012 then 0x0022; then fsm_done=1.
   -> writes {0x0012,0x0011}@0x200, then {0x0022,0x0021}@0x204 on consecutive cycles;
   -> wr_output_done pulses 1 cycle after the last write;
   -> wr_output_rdy returns 1 one cycle after fsm_done falls.
3. Stall: col0 valid held for 3 cycles with stall=1,1,0 -> exactly one capture into buf[0][0].
4. Overflow: col0 valid for 3 non-stall samples (0x1,0x2,0x3) -> err_overflow=1; row writes contain 0x1, 0x2; 0x3 is discarded.
5. Underflow: fsm_done rises after only col0 row0 = 0xAAAA -> err_underflow=1; writes {0x0000,0xAAAA}@0x200 and {0,0}@0x204.
6. Reset asserted on the DRAIN cycle after the row-0 write -> no row-1 write; next cycle wr_output_rdy=1, wr_mem_en=0.
